// File: rtl/rr_mux_pkg.sv
// Shared constants for the round-robin channel mux family.
package rr_mux_pkg;
   localparam logic MODE_FIXED = 1'b0;
   localparam logic MODE_RR    = 1'b1;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority arbiter: searches ptr+1, ptr+2, ... wrapping
// modulo NUM_CH and ending at ptr itself; first requester wins.
module rr_arbiter #(
   parameter int NUM_CH = 4,
   parameter int CH_W   = $clog2(NUM_CH)
) (
   input  logic [NUM_CH-1:0] req,
   input  logic [CH_W-1:0]   ptr,
   output logic [NUM_CH-1:0] gnt,
   output logic [CH_W-1:0]   idx,
   output logic              any
);

   always_comb begin
      logic [CH_W-1:0] k;
      gnt = '0;
      idx = '0;
      any = 1'b0;
      k   = ptr;
      for (int i = 0; i < NUM_CH; i++) begin
         // explicit wrap keeps non-power-of-two channel counts modulo NUM_CH
         k = (k == CH_W'(NUM_CH - 1)) ? '0 : k + CH_W'(1);
         if (!any && req[k]) begin
            any    = 1'b1;
            gnt[k] = 1'b1;
            idx    = k;
         end
      end
   end

endmodule

// File: rtl/rr_chan_mux.sv
// N-channel valid/ready stream mux with fixed-select or round-robin arbitration
// and a single registered output stage (1 word/cycle sustained).
module rr_chan_mux
   import rr_mux_pkg::*;
#(
   parameter  int NUM_CH = 4,
   parameter  int DATA_W = 8,
   localparam int CH_W   = $clog2(NUM_CH)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     mode,
   input  logic [CH_W-1:0]          sel,
   input  logic [NUM_CH*DATA_W-1:0] in_data,
   input  logic [NUM_CH-1:0]        in_valid,
   output logic [NUM_CH-1:0]        in_ready,
   output logic [DATA_W-1:0]        out_data,
   output logic [CH_W-1:0]          out_ch,
   output logic                     out_valid,
   input  logic                     out_ready
);

   logic                load, sel_ok, rr_any, gnt_ok, xfer;
   logic [CH_W-1:0]     rr_ptr, rr_idx, g;
   logic [NUM_CH-1:0]   rr_gnt, gnt_oh;
   logic [DATA_W-1:0]   ch_data [NUM_CH];

   for (genvar k = 0; k < NUM_CH; k++) begin : g_unpack
      assign ch_data[k] = in_data[k*DATA_W +: DATA_W];
   end

   rr_arbiter #(
      .NUM_CH (NUM_CH)
   ) u_arb (
      .req (in_valid),
      .ptr (rr_ptr),
      .gnt (rr_gnt),
      .idx (rr_idx),
      .any (rr_any)
   );

   assign load   = !out_valid || out_ready;
   assign sel_ok = {1'b0, sel} < (CH_W+1)'(NUM_CH);

   always_comb begin
      gnt_oh = '0;
      g      = sel;
      gnt_ok = sel_ok;
      if (mode == MODE_RR) begin
         gnt_oh = rr_gnt;
         g      = rr_idx;
         gnt_ok = rr_any;
      end else if (sel_ok) begin
         gnt_oh[sel] = 1'b1;
      end
   end

   // fixed mode may offer ready on an idle channel; that is harmless
   assign in_ready = (load && gnt_ok && !rst) ? gnt_oh : '0;
   assign xfer     = |(in_ready & in_valid);

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_ch    <= '0;
         rr_ptr    <= CH_W'(NUM_CH - 1);
      end else if (xfer) begin
         out_valid <= 1'b1;
         out_data  <= ch_data[g];
         out_ch    <= g;
         if (mode == MODE_RR)
            rr_ptr <= g;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: doc/rr_chan_mux.md
Name: rr_chan_mux

Overview:
- Parametrised N-channel, W-bit streaming multiplexer. It is the sequential successor to the team's fixed 4:1 combinational mux.
- Each input channel has a valid/ready handshake. The block selects one channel per transfer and captures its word into a registered output stage.
- Two arbitration modes: fixed select (sel port chooses the channel) and round-robin.
- Sits between multiple producers and a single downstream consumer.

Parameters:
- NUM_CH, 4, number of input channels (>=2).
- DATA_W, 8, data width per channel.
- CH_W, $clog2(NUM_CH), width of channel index (derived; not overridden).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- mode  in  1  0 = fixed select via sel; 1 = round-robin.
- sel  in  CH_W  channel select, used only when mode=0.
- in_data  in  NUM_CH*DATA_W  packed channel data; channel k occupies bits [k*DATA_W +: DATA_W].
- in_valid  in  NUM_CH  per-channel valid.
- in_ready  out  NUM_CH  per-channel ready; one-hot or zero.
- out_data  out  DATA_W  registered output word.
- out_ch  out  CH_W  index of the channel that produced out_data.
- out_valid  out  1  output word valid.
- out_ready  in  1  downstream accept.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset (rst=1 at a clock edge):
  - out_valid=0, out_data=0, out_ch=0, rr_ptr=NUM_CH-1, so channel 0 has first round-robin priority.
  - in_ready=0 while rst=1.
- Load enable: load = !out_valid || out_ready (combinational). The output stage accepts a new word whenever it is empty or being drained in the same cycle.
- Grant is computed combinationally each cycle.
  - Mode 0: grant channel g = sel if sel < NUM_CH. If sel >= NUM_CH, there is no grant.
  - Mode 1: g = first k with in_valid[k]=1, searching rr_ptr+1, rr_ptr+2, ..., wrapping modulo NUM_CH and ending at rr_ptr itself. If no channel is valid, there is no grant.
- in_ready[g] = load. All other in_ready bits are 0.
  - Mode 0: in_ready[sel] may be 1 even when in_valid[sel]=0.
  - Mode 1: in_ready is 0 for every channel when no channel is valid.
- Transfer on channel g: in_valid[g] && in_ready[g] at a clock edge. On a transfer:
  - out_data <= in_data[g], out_ch <= g, out_valid <= 1.
  - Mode 1 only: rr_ptr <= g.
- Output drain without a new word: out_valid && out_ready with no input transfer in the same cycle gives out_valid <= 0. out_data and out_ch hold their last values.
- Simultaneous drain and load: the new word replaces the old one in the same edge and out_valid stays 1. This sustains full throughput of 1 word/cycle.
- Latency: 1 cycle from input transfer to out_valid.
- Backpressure: while out_valid=1 and out_ready=0, all in_ready=0 and out_data/out_ch/out_valid are held stable.
- rr_ptr changes only on a mode-1 transfer. Mode-0 transfers leave it unchanged.
- Mode or sel change: takes effect on the next grant evaluation. A word already held in the output register is unaffected.
- Reset mid-operation: the held word is discarded and out_valid=0 on the next cycle. No input transfer occurs in a reset cycle.
- NUM_CH not a power of two: round-robin wrap is modulo NUM_CH, never 2^CH_W.

Decomposition:
- Shared package rr_mux_pkg: mode constants MODE_FIXED=1'b0 and MODE_RR=1'b1.
- Sub-module rr_arbiter: NUM_CH request vector plus pointer in, one-hot grant plus encoded index out, purely combinational. It is reusable by future arbiters.
- Top-level module holds the output register, load logic and the pointer register.

Test Plan:
- Fixed mode, full throughput: NUM_CH=4, in_data={8'hD3,8'hC2,8'hB1,8'hA0}, all valid, out_ready=1, sel=0,1,2,3 on consecutive cycles -> out_data A0,B1,C2,D3 on the following cycles with out_ch 0..3 and out_valid continuously 1.
- Round-robin fairness: mode=1, all four channels constantly valid, out_ready=1 -> grants 0,1,2,3,0,1 on consecutive cycles, one in_ready bit high per cycle.
- Round-robin skip: only ch1 and ch3 valid -> grants alternate 1,3,1,3. Then drop ch3 valid -> ch1 granted every cycle.
- Backpressure: out_ready=0 for 3 cycles after word 8'hB1 is captured -> out_data=B1 and out_valid=1 held, in_ready=0. out_ready=1 -> B1 drains and the next word loads in the same edge.
- Invalid select and idle: mode=0, sel=3 with in_valid=4'b0000 -> out_valid stays 0 after drain. Repeat with NUM_CH=3, sel=3 -> no transfer, in_ready=0.
- Reset mid-stream: rst=1 while out_valid=1 holding 8'hC2 -> next cycle out_valid=0, out_data=0, out_ch=0. After release in mode 1 with all channels valid -> first grant is ch0.
